mips_wb_trace_fifo: RTL and testbench
=====================================

// Module: mips_wb_trace_fifo
// PURPOSE
//  Parametrised register-writeback trace capture for the MIPS multicycle core.
//  Snoops the writeback port (RegWrite/A3/WD3/PC) and queues each write event in a DEPTH-entry FIFO.
//  Each event carries a sequence tag. A valid/ready port drains the FIFO to the scoreboard/monitor side.
//  Sits beside the core; purely observational, never back-pressures the core.
// PARAMETERS
//  DATA_W  32  width of WD3 and PC
//  ADDR_W  5   width of A3 (register index)
//  DEPTH   8   FIFO entries; power of 2, >=2
//  SEQ_W   8   sequence-tag width; wraps modulo 2^SEQ_W
//  OVF_W   8   overflow-counter width; saturating
//  TS_W    16  timestamp width (used only with TRACE_TSTAMP_EN)
// PORTS
//  clk           in   1                    rising-edge clock
//  reset         in   1                    asynchronous, active-low reset
//  reg_write     in   1                    writeback strobe; 1 = capture this cycle
//  a3            in   ADDR_W               destination register of write
//  wd3           in   DATA_W               write data
//  pc            in   DATA_W               PC of the writing instruction
//  flush         in   1                    synchronous FIFO clear
//  out_valid     out  1                    head entry available
//  out_ready     in   1                    consumer accepts head
//  out_a3        out  ADDR_W               head entry register index
//  out_wd3       out  DATA_W               head entry data
//  out_pc        out  DATA_W               head entry PC
//  out_seq       out  SEQ_W                head entry sequence tag
//  out_tstamp    out  TS_W                 head entry timestamp (only with TRACE_TSTAMP_EN)
//  count         out  $clog2(DEPTH+1)      entries held
//  full          out  1                    count==DEPTH
//  overflow      out  1                    sticky: >=1 event dropped
//  overflow_cnt  out  OVF_W                dropped events, saturates at all-ones
// BEHAVIOUR
//  - Reset (reset==0, async): pointers, count, seq, overflow, overflow_cnt, timestamp all 0.
//    out_valid=0, full=0; out_* data = 0.
//  - Show-ahead FIFO: out_* driven from the head storage entry; out_valid = (count!=0).
//  - Push: at posedge, when reg_write==1 && !flush && (!full || pop).
//    Entry = {a3,wd3,pc,seq}; seq then increments.
//  - Latency: event sampled at edge N is visible on out_* with out_valid=1 after edge N (next cycle).
//  - Pop: at posedge when out_valid && out_ready; head advances.
//  - Simultaneous push+pop:
//    - full: both occur, count unchanged, no drop.
//    - empty: pop ignored (out_valid=0), push occurs.
//  - Drop: reg_write==1 && full && !pop -> event discarded, overflow<=1, overflow_cnt+1 (sat).
//    seq still increments, so consumer sees a tag gap.
//  - seq increments on every reg_write==1 cycle (captured, dropped or flushed); wraps 2^SEQ_W-1 -> 0.
//  - flush==1: at posedge, pointers/count/overflow/overflow_cnt <= 0; a pop or push that cycle is discarded.
//    seq and timestamp keep counting.
//  - Pointers are log2(DEPTH) bits and wrap naturally; count tracks occupancy.
//  - Writes to A3==0 are captured like any other.
//  - Mid-operation reset clears everything; entries in flight are lost, no partial outputs.
// CONFIGURATION
//  TRACE_TSTAMP_EN defined:
//    - free-running TS_W-bit cycle counter (reset 0, wraps);
//    - value at push edge stored per entry and presented on out_tstamp.
//  TRACE_TSTAMP_EN undefined: no counter, no storage, out_tstamp port absent.
// TESTING
//  1 Reset release, reg_write=1 a3=5 wd3=0xDEADBEEF pc=0x40 one cycle, out_ready=0
//    -> next cycle out_valid=1 out_a3=5 out_wd3=0xDEADBEEF out_pc=0x40 out_seq=0 count=1.
//  2 Push 8 events (DEPTH=8) with out_ready=0, then 2 more
//    -> full=1 count=8, overflow=1 overflow_cnt=2; drain shows seq 0..7; next push gets seq 10.
//  3 Full FIFO, reg_write=1 and out_ready=1 same cycle
//    -> count stays 8, overflow stays 0, head seq advances by 1.
//  4 Empty FIFO, reg_write=1 and out_ready=1 same cycle -> count=1, out_valid=1 next cycle.
//  5 3 entries held, overflow=1; flush=1 with reg_write=1
//    -> count=0, out_valid=0, overflow=0, overflow_cnt=0; seq still advanced by 1.
//  6 reset asserted mid-burst -> all outputs 0 immediately, without a clock edge.
//    With TRACE_TSTAMP_EN: push at cycle 3 after reset -> out_tstamp=3.

Source files
------------

// File: rtl/mips_wb_trace_fifo_if.sv
// Writeback snoop port and trace-drain port of the MIPS writeback trace FIFO.
// master: the core/monitor side; it drives the writeback strobe, flush and out_ready.
// slave: the trace FIFO; it drives out_* and the status outputs.
// With TRACE_TSTAMP_EN defined, out_tstamp and the TS_W parameter are present.
interface mips_wb_trace_fifo_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 8,
    parameter int OVF_W  = 8
`ifdef TRACE_TSTAMP_EN
    ,
    parameter int TS_W   = 16
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              reg_write;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;
    logic [DATA_W-1:0] pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_a3;
    logic [DATA_W-1:0] out_wd3;
    logic [DATA_W-1:0] out_pc;
    logic [SEQ_W-1:0]  out_seq;
`ifdef TRACE_TSTAMP_EN
    logic [TS_W-1:0]   out_tstamp;
`endif
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              overflow;
    logic [OVF_W-1:0]  overflow_cnt;

    modport master (
        output reg_write, a3, wd3, pc, flush, out_ready,
        input  out_valid, out_a3, out_wd3, out_pc, out_seq,
`ifdef TRACE_TSTAMP_EN
        input  out_tstamp,
`endif
        input  count, full, overflow, overflow_cnt
    );

    modport slave (
        input  reg_write, a3, wd3, pc, flush, out_ready,
        output out_valid, out_a3, out_wd3, out_pc, out_seq,
`ifdef TRACE_TSTAMP_EN
        output out_tstamp,
`endif
        output count, full, overflow, overflow_cnt
    );
endinterface

// File: rtl/mips_wb_trace_fifo.sv
// Register-writeback trace capture: queues {a3,wd3,pc,seq} per write in a show-ahead DEPTH-entry FIFO.
// Latency: an event sampled at edge N is on out_* with out_valid=1 after edge N.
// Backpressure: never stalls the core; when full without a pop the event is dropped and counted.
// Ports: clk, reset (async, active-low), bus (slave modport: snoop inputs, flush, valid/ready drain, status).
// Optional feature macro TRACE_TSTAMP_EN: adds a free-running cycle stamp per entry on out_tstamp.
module mips_wb_trace_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 8,
    parameter int OVF_W  = 8
`ifdef TRACE_TSTAMP_EN
    ,
    parameter int TS_W   = 16
`endif
) (
    input logic                clk,
    input logic                reset,
    mips_wb_trace_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             ovf_q, ovf_d;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic [ADDR_W-1:0] a3_mem  [DEPTH];
    logic [DATA_W-1:0] wd3_mem [DEPTH];
    logic [DATA_W-1:0] pc_mem  [DEPTH];
    logic [SEQ_W-1:0]  seq_mem [DEPTH];
`ifdef TRACE_TSTAMP_EN
    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   ts_mem  [DEPTH];
`endif

    logic valid;
    logic full;
    logic pop_req;   // consumer handshake, before flush cancels it
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        valid   = (count_q != '0);
        full    = (count_q == CNT_W'(DEPTH));
        pop_req = valid && bus.out_ready;
        pop     = pop_req && !bus.flush;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push    = bus.reg_write && !bus.flush && (!full || pop_req);
        drop    = bus.reg_write && !bus.flush && full && !pop_req;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        // Tag advances on every strobe so dropped or flushed events leave a visible gap.
        seq_d     = bus.reg_write ? seq_q + SEQ_W'(1) : seq_q;

        if (bus.flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            if (drop) begin
                ovf_d = 1'b1;
                if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            seq_q     <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            seq_q     <= seq_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

`ifdef TRACE_TSTAMP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end
`endif

    // Storage needs no reset: the head is only exposed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            a3_mem[wr_ptr_q]  <= bus.a3;
            wd3_mem[wr_ptr_q] <= bus.wd3;
            pc_mem[wr_ptr_q]  <= bus.pc;
            seq_mem[wr_ptr_q] <= seq_q;
`ifdef TRACE_TSTAMP_EN
            ts_mem[wr_ptr_q]  <= ts_q;
`endif
        end
    end

    // Data is gated by valid so reset and flush present all-zero outputs.
    always_comb begin
        bus.out_valid    = valid;
        bus.out_a3       = valid ? a3_mem[rd_ptr_q]  : '0;
        bus.out_wd3      = valid ? wd3_mem[rd_ptr_q] : '0;
        bus.out_pc       = valid ? pc_mem[rd_ptr_q]  : '0;
        bus.out_seq      = valid ? seq_mem[rd_ptr_q] : '0;
`ifdef TRACE_TSTAMP_EN
        bus.out_tstamp   = valid ? ts_mem[rd_ptr_q]  : '0;
`endif
        bus.count        = count_q;
        bus.full         = full;
        bus.overflow     = ovf_q;
        bus.overflow_cnt = ovf_cnt_q;
    end
endmodule

// File: tb/tb_mips_wb_trace_fifo.sv
module tb_mips_wb_trace_fifo;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mips_wb_trace_fifo_if bus ();

    mips_wb_trace_fifo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.reg_write = 1'b0;
        bus.a3        = '0;
        bus.wd3       = '0;
        bus.pc        = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic push_n(input int n, input int base);
        bus.reg_write = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.a3  = 5'(i);
            bus.wd3 = 32'(base + i);
            bus.pc  = 32'h100 + 32'(4 * i);
            tick();
        end
        bus.reg_write = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle_inputs();
        tick();
        tick();

        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);
        chk("rst_ovf_cnt", 64'(bus.overflow_cnt), 64'd0);
        chk("rst_wd3", 64'(bus.out_wd3), 64'd0);
        reset = 1'b1;

        // Single capture, visible one edge later.
        bus.reg_write = 1'b1;
        bus.a3        = 5'd5;
        bus.wd3       = 32'hDEADBEEF;
        bus.pc        = 32'h40;
        tick();
        idle_inputs();
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_a3", 64'(bus.out_a3), 64'd5);
        chk("t1_wd3", 64'(bus.out_wd3), 64'hDEADBEEF);
        chk("t1_pc", 64'(bus.out_pc), 64'h40);
        chk("t1_seq", 64'(bus.out_seq), 64'd0);
        chk("t1_count", 64'(bus.count), 64'd1);

        // Fresh reset, then 10 pushes into 8 slots.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        push_n(10, 32'h1000);
        chk("t2_full", 64'(bus.full), 64'd1);
        chk("t2_count", 64'(bus.count), 64'd8);
        chk("t2_ovf", 64'(bus.overflow), 64'd1);
        chk("t2_ovf_cnt", 64'(bus.overflow_cnt), 64'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain_seq", 64'(bus.out_seq), 64'(i));
            chk("t2_drain_wd3", 64'(bus.out_wd3), 64'(32'h1000 + i));
            tick();
        end
        bus.out_ready = 1'b0;
        chk("t2_empty", 64'(bus.out_valid), 64'd0);
        push_n(1, 32'h2000);
        chk("t2_next_seq", 64'(bus.out_seq), 64'd10);

        // Full FIFO, push and pop together (seq counter now 11).
        do_flush();
        chk("t3_flush_ovf", 64'(bus.overflow), 64'd0);
        chk("t3_flush_cnt", 64'(bus.count), 64'd0);
        push_n(8, 32'h3000);
        chk("t3_head", 64'(bus.out_seq), 64'd11);
        bus.reg_write = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        idle_inputs();
        chk("t3_count", 64'(bus.count), 64'd8);
        chk("t3_ovf", 64'(bus.overflow), 64'd0);
        chk("t3_head_adv", 64'(bus.out_seq), 64'd12);

        // Empty FIFO, push and pop together; also a write to register 0.
        do_flush();
        bus.reg_write = 1'b1;
        bus.a3        = 5'd0;
        bus.wd3       = 32'h1234;
        bus.out_ready = 1'b1;
        tick();
        idle_inputs();
        chk("t4_count", 64'(bus.count), 64'd1);
        chk("t4_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_a3", 64'(bus.out_a3), 64'd0);
        chk("t4_wd3", 64'(bus.out_wd3), 64'h1234);
        chk("t4_seq", 64'(bus.out_seq), 64'd20);

        // Three entries with overflow set, then flush together with a strobe.
        do_flush();
        push_n(9, 32'h4000);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.out_ready = 1'b0;
        chk("t5_pre_count", 64'(bus.count), 64'd3);
        chk("t5_pre_ovf", 64'(bus.overflow), 64'd1);
        chk("t5_pre_head", 64'(bus.out_seq), 64'd26);
        bus.flush     = 1'b1;
        bus.reg_write = 1'b1;
        tick();
        idle_inputs();
        chk("t5_count", 64'(bus.count), 64'd0);
        chk("t5_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_ovf", 64'(bus.overflow), 64'd0);
        chk("t5_ovf_cnt", 64'(bus.overflow_cnt), 64'd0);
        push_n(1, 32'h5000);
        chk("t5_seq_gap", 64'(bus.out_seq), 64'd31);

        // Drop counter saturates at all-ones.
        do_flush();
        push_n(8, 32'h6000);
        push_n(260, 32'h7000);
        chk("sat_ovf_cnt", 64'(bus.overflow_cnt), 64'hFF);
        chk("sat_count", 64'(bus.count), 64'd8);

        // Asynchronous reset in the middle of a burst.
        bus.reg_write = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_count", 64'(bus.count), 64'd0);
        chk("t6_full", 64'(bus.full), 64'd0);
        chk("t6_ovf", 64'(bus.overflow), 64'd0);
        chk("t6_ovf_cnt", 64'(bus.overflow_cnt), 64'd0);
        chk("t6_wd3", 64'(bus.out_wd3), 64'd0);
        chk("t6_seq", 64'(bus.out_seq), 64'd0);
        idle_inputs();
        tick();
        reset = 1'b1;
        push_n(1, 32'h8000);
        chk("t6_seq_restart", 64'(bus.out_seq), 64'd0);

`ifdef TRACE_TSTAMP_EN
        // Stamp counter runs 0,1,2,... from the first edge after release.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        tick();
        tick();
        push_n(1, 32'h9000);
        chk("ts_value", 64'(bus.out_tstamp), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
